// File: rtl/mapping_frame_sequencer.sv
// Frame-level controller for one crate mapper: finds the sync word, times the
// accumulate window, captures the trailer frame ID and sequences valid/clear strobes.
module mapping_frame_sequencer #(
    parameter int          NWORDS = 16,
    parameter logic [15:0] SYNC   = 16'hAAAA,
    parameter int          FID_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      fiber,
    input  logic             en,
    output logic             acc_en,
    output logic [5:0]       word_idx,
    output logic             out_valid,
    output logic [FID_W-1:0] frame_id,
    output logic             clr,
    output logic             busy,
    output logic             fid_err,
    output logic [15:0]      frame_cnt,
    output logic [7:0]       err_cnt
);

    typedef enum logic [2:0] {IDLE, ACCUM, TRAILER, DONE, CLEAR} state_t;

    localparam logic [5:0] LAST_IDX = 6'(NWORDS - 1);

    state_t           state;
    logic             first_frame;
    logic             start;
    logic [FID_W-1:0] fid_in;
    logic [FID_W-1:0] fid_exp;
    logic             mismatch;

    assign start    = en && (fiber == SYNC);
    assign fid_in   = fiber[FID_W-1:0];
    assign fid_exp  = frame_id + FID_W'(1);
    // The first frame after reset has no predecessor to compare against.
    assign mismatch = !first_frame && (fid_in != fid_exp);

    assign acc_en    = (state == ACCUM);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign clr       = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word_idx    <= '0;
            frame_id    <= '0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
            fid_err     <= 1'b0;
            first_frame <= 1'b1;
        end else begin
            fid_err <= 1'b0;
            case (state)
                IDLE: begin
                    word_idx <= '0;
                    if (start) state <= ACCUM;
                end
                ACCUM: begin
                    // Data words equal to SYNC are plain data here.
                    if (word_idx == LAST_IDX) begin
                        word_idx <= '0;
                        state    <= TRAILER;
                    end else begin
                        word_idx <= word_idx + 6'd1;
                    end
                end
                TRAILER: begin
                    // Results land together with out_valid in DONE.
                    frame_id    <= fid_in;
                    fid_err     <= mismatch;
                    frame_cnt   <= frame_cnt + 16'd1;
                    if (mismatch && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    first_frame <= 1'b0;
                    state       <= DONE;
                end
                DONE: state <= CLEAR;
                CLEAR: begin
                    word_idx <= '0;
                    state    <= start ? ACCUM : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mapping_frame_sequencer.sv
// Bench for mapping_frame_sequencer: table of frames, directed corner sequences,
// and a randomized stream checked against a schedule-based reference model.
module tb_mapping_frame_sequencer;

    localparam int          NW = 16;
    localparam int          FW = 10;
    localparam logic [15:0] SY = 16'hAAAA;
    localparam int          N  = 1500;

    logic          clk = 1'b0;
    logic          rst, en;
    logic [15:0]   fiber;
    logic          acc_en, out_valid, clr, busy, fid_err;
    logic [5:0]    word_idx;
    logic [FW-1:0] frame_id;
    logic [15:0]   frame_cnt;
    logic [7:0]    err_cnt;

    mapping_frame_sequencer #(.NWORDS(NW), .SYNC(SY), .FID_W(FW)) dut (
        .clk(clk), .rst(rst), .fiber(fiber), .en(en),
        .acc_en(acc_en), .word_idx(word_idx), .out_valid(out_valid),
        .frame_id(frame_id), .clr(clr), .busy(busy), .fid_err(fid_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] fid;
        logic        en_mid;
        bit          d3_sync;
        bit          err;
        int          fcnt;
        int          ecnt;
    } row_t;
    row_t tbl[6];

    logic [15:0] rw[N];
    bit          ren[N];
    bit          eacc[N], eov[N], eclr[N], ebz[N], efe[N];
    int          eix[N], efid[N], efc[N], eec[N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs; on return the outputs show the next cycle.
    task automatic tick(input logic e, input logic [15:0] w);
        en = e;
        fiber = w;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 16'h0);
        tick(1'b0, 16'h0);
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " acc_en"}, acc_en, 0);
        chk({tag, " word_idx"}, word_idx, 0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " clr"}, clr, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " fid_err"}, fid_err, 0);
        chk({tag, " frame_id"}, frame_id, 0);
        chk({tag, " frame_cnt"}, frame_cnt, 0);
        chk({tag, " err_cnt"}, err_cnt, 0);
    endtask

    // Called in the first data cycle; returns in the out_valid cycle.
    task automatic frame_body(input logic [15:0] fid, input logic en_mid, input bit d3_sync);
        for (int i = 0; i < NW; i++) begin
            chk("acc_en", acc_en, 1);
            chk("word_idx", word_idx, i);
            tick(en_mid, (d3_sync && i == 3) ? SY : 16'($urandom_range(0, 16'h7FFF)));
        end
        chk("trailer acc_en", acc_en, 0);
        chk("trailer busy", busy, 1);
        tick(en_mid, fid);
    endtask

    task automatic run_random();
        int pos, tr, lastf, fid, fc, ec, t;
        bit first, mis;
        for (int c = 0; c < N; c++) begin
            rw[c]  = ($urandom_range(0, 5) == 0) ? SY : 16'($urandom);
            ren[c] = ($urandom_range(0, 3) != 0);
            eacc[c] = 0; eov[c] = 0; eclr[c] = 0; ebz[c] = 0; efe[c] = 0; eix[c] = 0;
        end
        // Frame schedule: a start is possible only where the sequencer is idle or clearing.
        pos = 0;
        lastf = 0;
        while (pos < N) begin
            if (ren[pos] && rw[pos] == SY) begin
                for (int i = 0; i < NW + 3; i++) begin
                    if (pos + 1 + i < N) begin
                        ebz[pos + 1 + i] = 1;
                        if (i < NW) begin
                            eacc[pos + 1 + i] = 1;
                            eix[pos + 1 + i]  = i;
                        end
                    end
                end
                tr = pos + NW + 1;
                if (tr < N) begin
                    if ($urandom_range(0, 1) == 1) rw[tr][FW-1:0] = FW'(lastf + 1);
                    lastf = int'(rw[tr][FW-1:0]);
                end
                if (tr + 1 < N) eov[tr + 1] = 1;
                if (tr + 2 < N) eclr[tr + 2] = 1;
                pos = pos + NW + 3;
            end else begin
                pos++;
            end
        end
        fid = 0; fc = 0; ec = 0; first = 1;
        for (int c = 0; c < N; c++) begin
            if (eov[c]) begin
                t   = int'(rw[c - 1][FW-1:0]);
                mis = !first && (t != (fid + 1) % (1 << FW));
                fid = t;
                fc  = (fc + 1) % 65536;
                if (mis && ec < 255) ec++;
                first  = 0;
                efe[c] = mis;
            end
            efid[c] = fid; efc[c] = fc; eec[c] = ec;
        end
        for (int c = 0; c < N; c++) begin
            chk($sformatf("rnd acc_en c%0d", c), acc_en, eacc[c]);
            chk($sformatf("rnd word_idx c%0d", c), word_idx, eix[c]);
            chk($sformatf("rnd out_valid c%0d", c), out_valid, eov[c]);
            chk($sformatf("rnd clr c%0d", c), clr, eclr[c]);
            chk($sformatf("rnd busy c%0d", c), busy, ebz[c]);
            chk($sformatf("rnd fid_err c%0d", c), fid_err, efe[c]);
            chk($sformatf("rnd frame_id c%0d", c), frame_id, efid[c]);
            chk($sformatf("rnd frame_cnt c%0d", c), frame_cnt, efc[c]);
            chk($sformatf("rnd err_cnt c%0d", c), err_cnt, eec[c]);
            tick(ren[c], rw[c]);
        end
    endtask

    initial begin
        int c0, c1;
        tbl[0] = '{16'h0005, 1'b1, 0, 0, 1, 0};
        tbl[1] = '{16'h0006, 1'b1, 0, 0, 2, 0};
        tbl[2] = '{16'h0008, 1'b1, 0, 1, 3, 1};
        tbl[3] = '{16'h03FF, 1'b1, 1, 1, 4, 2};
        tbl[4] = '{16'h0000, 1'b0, 0, 0, 5, 2};
        tbl[5] = '{16'hF001, 1'b1, 0, 0, 6, 2};

        rst = 1'b1; en = 1'b0; fiber = 16'h0;
        do_reset();
        chk_idle("reset");

        tick(1'b0, SY);
        chk("en0 busy", busy, 0);
        chk("en0 acc_en", acc_en, 0);

        foreach (tbl[r]) begin
            tick(1'b1, SY);
            c0 = cyc;
            frame_body(tbl[r].fid, tbl[r].en_mid, tbl[r].d3_sync);
            chk("ov latency", cyc - c0, NW + 1);
            chk("out_valid", out_valid, 1);
            chk("frame_id", frame_id, tbl[r].fid[FW-1:0]);
            chk("fid_err", fid_err, tbl[r].err);
            chk("frame_cnt", frame_cnt, tbl[r].fcnt);
            chk("err_cnt", err_cnt, tbl[r].ecnt);
            chk("clr early", clr, 0);
            tick(1'b1, 16'h1234);
            chk("clr", clr, 1);
            chk("clr out_valid", out_valid, 0);
            chk("clr fid_err", fid_err, 0);
            chk("clr busy", busy, 1);
            tick(1'b1, 16'h0);
            chk("idle busy", busy, 0);
            chk("idle clr", clr, 0);
        end

        // Back-to-back: sync in the CLEAR cycle.
        tick(1'b1, SY);
        frame_body(16'h0002, 1'b1, 0);
        chk("b2b first ov", out_valid, 1);
        c1 = cyc;
        tick(1'b1, 16'h0);
        chk("b2b clr", clr, 1);
        tick(1'b1, SY);
        chk("b2b busy", busy, 1);
        frame_body(16'h0003, 1'b1, 0);
        chk("b2b second ov", out_valid, 1);
        chk("b2b spacing", cyc - c1, NW + 3);
        chk("b2b fid_err", fid_err, 0);
        chk("b2b frame_cnt", frame_cnt, 8);
        tick(1'b1, 16'h0);
        tick(1'b1, 16'h0);

        // Reset in the middle of the accumulate window.
        tick(1'b1, SY);
        for (int i = 0; i < 7; i++) tick(1'b1, 16'h0100);
        chk("pre-rst word_idx", word_idx, 7);
        rst = 1'b1;
        tick(1'b1, 16'h0);
        rst = 1'b0;
        chk_idle("midrst");
        tick(1'b1, SY);
        frame_body(16'h0123, 1'b1, 0);
        chk("post-rst ov", out_valid, 1);
        chk("post-rst fid_err", fid_err, 0);
        chk("post-rst frame_id", frame_id, 10'h123);
        chk("post-rst frame_cnt", frame_cnt, 1);
        tick(1'b1, 16'h0);
        tick(1'b1, 16'h0);

        // 300 repeated IDs after a first frame saturate the error counter.
        do_reset();
        for (int k = 0; k < 301; k++) begin
            tick(1'b1, SY);
            frame_body(16'h0055, 1'b1, 0);
            tick(1'b1, 16'h0);
            tick(1'b1, 16'h0);
        end
        chk("sat err_cnt", err_cnt, 255);
        chk("sat frame_cnt", frame_cnt, 301);

        do_reset();
        run_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
